// File: rtl/clk_div_multi.sv
// Multi-channel glitch-safe programmable clock divider; ratio changes take effect at period boundaries.
// Optional per-channel divided-domain tick output enabled by defining CLKDIV_TICK_EN.
module clk_div_multi #(
  parameter int unsigned CHANNELS      = 2,
  parameter int unsigned RATIO_WIDTH   = 8,
  parameter int unsigned DEFAULT_RATIO = 2
) (
  input  logic                            i_ref_clk,
  input  logic                            i_rst,
  input  logic [CHANNELS-1:0]             i_clk_en,
  input  logic [CHANNELS*RATIO_WIDTH-1:0] i_div_ratio,
  input  logic [CHANNELS-1:0]             i_ratio_load,
  input  logic                            i_sync,
  output logic [CHANNELS-1:0]             o_div_clk,
  output logic [CHANNELS-1:0]             o_ratio_pending
`ifdef CLKDIV_TICK_EN
  ,
  output logic [CHANNELS-1:0]             o_tick
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_BYPASS
  } state_t;

  localparam logic [RATIO_WIDTH-1:0] ONE       = RATIO_WIDTH'(1);
  localparam logic [RATIO_WIDTH-1:0] TWO       = RATIO_WIDTH'(2);
  localparam logic [RATIO_WIDTH-1:0] RST_RATIO = RATIO_WIDTH'(DEFAULT_RATIO);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    state_t                 state_q, state_d;
    logic [RATIO_WIDTH-1:0] ratio_q, ratio_d;
    logic [RATIO_WIDTH-1:0] pend_q, pend_d;
    logic [RATIO_WIDTH-1:0] cnt_q, cnt_d;
    logic                   pflag_q, pflag_d;
    logic                   div_q, div_d;
    logic                   en, terminal, restart_req, apply;
    logic [RATIO_WIDTH-1:0] r_eff, high_len, cnt_inc;

    assign en          = i_clk_en[c];
    assign high_len    = ratio_q - (ratio_q >> 1);
    assign cnt_inc     = cnt_q + ONE;
    // RUN always holds R >= 2, so R-1 cannot wrap where it matters
    assign terminal    = (state_q == ST_RUN) && (cnt_q == ratio_q - ONE);
    assign restart_req = terminal || ((state_q == ST_RUN) && i_sync && en);
    assign apply       = pflag_q && ((state_q != ST_RUN) || restart_req);
    assign r_eff       = apply ? pend_q : ratio_q;

    always_comb begin
      state_d = state_q;
      ratio_d = apply ? pend_q : ratio_q;
      pend_d  = pend_q;
      pflag_d = pflag_q;
      cnt_d   = cnt_q;
      div_d   = div_q;

      if (i_ratio_load[c]) begin
        pend_d  = i_div_ratio[c*RATIO_WIDTH +: RATIO_WIDTH];
        pflag_d = 1'b1;
      end else if (apply) begin
        pflag_d = 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          div_d = 1'b0;
          if (en) begin
            if (r_eff >= TWO) begin
              state_d = ST_RUN;
              div_d   = 1'b1;
            end else begin
              state_d = ST_BYPASS;
            end
          end
        end
        ST_RUN: begin
          if (restart_req) begin
            cnt_d = '0;
            if (!en) begin
              state_d = ST_IDLE;
              div_d   = 1'b0;
            end else if (r_eff < TWO) begin
              state_d = ST_BYPASS;
              div_d   = 1'b0;
            end else begin
              div_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_inc;
            div_d = (cnt_inc < high_len);
          end
        end
        ST_BYPASS: begin
          cnt_d = '0;
          div_d = 1'b0;
          if (!en || (r_eff >= TWO)) state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          div_d   = 1'b0;
        end
      endcase
    end

    always_ff @(posedge i_ref_clk or posedge i_rst) begin
      if (i_rst) begin
        state_q <= ST_IDLE;
        ratio_q <= RST_RATIO;
        pend_q  <= '0;
        pflag_q <= 1'b0;
        cnt_q   <= '0;
        div_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        ratio_q <= ratio_d;
        pend_q  <= pend_d;
        pflag_q <= pflag_d;
        cnt_q   <= cnt_d;
        div_q   <= div_d;
      end
    end

    assign o_div_clk[c]       = (state_q == ST_BYPASS) ? i_ref_clk : div_q;
    assign o_ratio_pending[c] = pflag_q;

`ifdef CLKDIV_TICK_EN
    logic tick_q;
    // In RUN, cnt is only reloaded with zero when a new high phase starts
    always_ff @(posedge i_ref_clk or posedge i_rst) begin
      if (i_rst) tick_q <= 1'b0;
      else       tick_q <= (state_d == ST_BYPASS) || ((state_d == ST_RUN) && (cnt_d == '0));
    end
    assign o_tick[c] = tick_q;
`endif
  end

endmodule
